// File: rtl/reset_sequencer_pkg.sv
// Shared types and sizing helpers for the reset sequencer and its siblings.
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    IDLE    = 2'd2
  } seq_state_e;

  function automatic int max_clog2(input int a, input int b);
    int ca;
    int cb;
    ca = $clog2(a);
    cb = $clog2(b);
    return (ca > cb) ? ca : cb;
  endfunction

endpackage

// File: rtl/reset_sync.sv
// Two-flop reset synchroniser: asserts asynchronously, releases on the second CLK edge.
module reset_sync (
  input  logic CLK,
  input  logic RST_N,
  output logic rst_ok
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[0], 1'b1};
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign rst_ok = sync_q[1];

endmodule

// File: rtl/reset_sequencer.sv
// Holds NCHAN active-low resets for RSTHOLD cycles, then releases them one by one
// STAGGER cycles apart; SW_RST restarts the whole sequence.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int NCHAN   = 4,
  parameter int RSTHOLD = 16,
  parameter int STAGGER = 4,
  parameter int CNTW    = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             SW_RST,
  output logic [NCHAN-1:0] OUT_RST_N,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNTW-1:0]  SW_CNT
);

  localparam int CW = max_clog2(RSTHOLD, STAGGER) + 1;
  localparam int IW = $clog2(NCHAN) + 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(RSTHOLD - 1);
  localparam logic [CW-1:0] STAG_LAST = CW'(STAGGER - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NCHAN - 1);

  logic             rst_ok;
  seq_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [NCHAN-1:0] out_q, out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNTW-1:0]  sw_cnt_q, sw_cnt_d;

  reset_sync u_reset_sync (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .rst_ok (rst_ok)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    out_d    = out_q;
    done_d   = 1'b0;
    sw_cnt_d = sw_cnt_q;
    if (rst_ok) begin
      // A software request overrides any release scheduled for the same edge.
      if (SW_RST) begin
        out_d   = '0;
        cnt_d   = '0;
        idx_d   = '0;
        state_d = HOLD;
        if (sw_cnt_q != '1) begin
          sw_cnt_d = sw_cnt_q + 1'b1;
        end
      end else begin
        case (state_q)
          HOLD: begin
            if (cnt_q == HOLD_LAST) begin
              out_d[0] = 1'b1;
              cnt_d    = '0;
              idx_d    = IW'(1);
              if (NCHAN == 1) begin
                state_d = IDLE;
                done_d  = 1'b1;
              end else begin
                state_d = RELEASE;
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          RELEASE: begin
            if (cnt_q == STAG_LAST) begin
              cnt_d = '0;
              for (int k = 0; k < NCHAN; k++) begin
                if (idx_q == IW'(k)) begin
                  out_d[k] = 1'b1;
                end
              end
              idx_d = idx_q + 1'b1;
              if (idx_q == IDX_LAST) begin
                state_d = IDLE;
                done_d  = 1'b1;
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          IDLE: begin
          end
          default: begin
            state_d = HOLD;
          end
        endcase
      end
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= HOLD;
      cnt_q    <= '0;
      idx_q    <= '0;
      out_q    <= '0;
      busy_q   <= 1'b1;
      done_q   <= 1'b0;
      sw_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      out_q    <= out_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sw_cnt_q <= sw_cnt_d;
    end
  end

  assign OUT_RST_N = out_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign SW_CNT    = sw_cnt_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench: a release-timeline model pushes expected outputs each posedge,
// the monitor pops and compares on the following negedge.
module tb_reset_sequencer;

  localparam int NA = 4, RA = 16, SA = 4;
  localparam int NB = 1, RB = 1, SB = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sw;
  logic       sw_b;
  logic [3:0] out_a;
  logic       busy_a, done_a;
  logic [7:0] cnt_a;
  logic [0:0] out_b;
  logic       busy_b, done_b;
  logic [7:0] cnt_b;

  always #5 clk = ~clk;

  reset_sequencer #(.NCHAN(NA), .RSTHOLD(RA), .STAGGER(SA), .CNTW(8)) dut_a (
    .CLK(clk), .RST_N(rst_n), .SW_RST(sw),
    .OUT_RST_N(out_a), .BUSY(busy_a), .DONE(done_a), .SW_CNT(cnt_a)
  );

  reset_sequencer #(.NCHAN(NB), .RSTHOLD(RB), .STAGGER(SB), .CNTW(8)) dut_b (
    .CLK(clk), .RST_N(rst_n), .SW_RST(sw_b),
    .OUT_RST_N(out_b), .BUSY(busy_b), .DONE(done_b), .SW_CNT(cnt_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  typedef struct {
    logic [3:0] out;
    logic       busy;
    logic       done;
    logic [7:0] cnt;
    logic       outb;
    logic       busyb;
    logic       doneb;
  } exp_t;

  exp_t q[$];

  // Channel k is released at origin + hold + k*stagger, where origin is the
  // edge rst_ok first reads high or the last accepted SW_RST edge.
  function automatic logic [3:0] rel_mask(int origin, int e, int n, int r, int s);
    logic [3:0] v;
    v = '0;
    if (origin >= 0) begin
      for (int k = 0; k < n; k++) begin
        if (e >= origin + r + k * s) v[k] = 1'b1;
      end
    end
    return v;
  endfunction

  int e_n = 0;
  int hi = 0;
  int origin_a = -1;
  int origin_b = -1;
  int swc = 0;

  always @(posedge clk) begin
    exp_t x;
    e_n++;
    if (!rst_n) begin
      hi = 0; origin_a = -1; origin_b = -1; swc = 0;
    end else begin
      if (hi == 1) begin
        origin_a = e_n; origin_b = e_n;
      end else if (hi >= 2 && sw) begin
        origin_a = e_n;
        if (swc < 255) swc++;
      end
      if (hi < 2) hi++;
    end
    x.out   = rel_mask(origin_a, e_n, NA, RA, SA);
    x.busy  = (x.out != 4'hF);
    x.done  = (origin_a >= 0) && (e_n == origin_a + RA + (NA - 1) * SA);
    x.cnt   = swc[7:0];
    x.outb  = rel_mask(origin_b, e_n, NB, RB, SB) != 4'h0;
    x.busyb = !x.outb;
    x.doneb = (origin_b >= 0) && (e_n == origin_b + RB + (NB - 1) * SB);
    q.push_back(x);
  end

  always @(negedge clk) begin
    exp_t x;
    if (q.size() > 0) begin
      x = q.pop_front();
      check("out_rst_n", out_a, x.out);
      check("busy", busy_a, x.busy);
      check("done", done_a, x.done);
      check("sw_cnt", cnt_a, x.cnt);
      check("b_out_rst_n", out_b, x.outb);
      check("b_busy", busy_b, x.busyb);
      check("b_done", done_b, x.doneb);
    end
  end

  task automatic reset_values(input string tag);
    check({tag, "_out"}, out_a, 4'h0);
    check({tag, "_cnt"}, cnt_a, 8'd0);
    check({tag, "_busy"}, busy_a, 1'b1);
    check({tag, "_done"}, done_a, 1'b0);
    check({tag, "_b_out"}, out_b, 1'b0);
  endtask

  // Asserts RST_N between clock edges, checks the immediate effect, then releases.
  task automatic apply_reset(input string tag);
    #2 rst_n = 1'b0;
    #1 reset_values(tag);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    sw    = 1'b0;
    sw_b  = 1'b0;
    #2 rst_n = 1'b0;
    #1 reset_values("por");
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("idle_cnt0", cnt_a, 8'd0);

    // Single SW_RST pulse while idle
    #2 sw = 1'b1;
    @(negedge clk);
    #2 sw = 1'b0;
    repeat (40) @(negedge clk);
    check("idle_cnt1", cnt_a, 8'd1);

    // SW_RST sampled on the edge channel 2 would release (E25)
    apply_reset("rst_a");
    repeat (25) @(negedge clk);
    #2 sw = 1'b1;
    @(negedge clk);
    #2 sw = 1'b0;
    repeat (45) @(negedge clk);
    check("rel_cnt1", cnt_a, 8'd1);

    // Asynchronous reset mid-HOLD, then mid-RELEASE, then a clean run
    apply_reset("rst_b");
    repeat (8) @(negedge clk);
    apply_reset("mid_hold");
    repeat (20) @(negedge clk);
    apply_reset("mid_rel");
    repeat (40) @(negedge clk);

    // SW_RST held for 300 cycles
    #2 sw = 1'b1;
    repeat (300) @(negedge clk);
    check("sat_cnt", cnt_a, 8'd255);
    check("sat_out", out_a, 4'h0);
    check("sat_busy", busy_a, 1'b1);
    #2 sw = 1'b0;
    repeat (40) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
